// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared MemOp codes, FSM encoding and request checks for the data-memory access controller
package dmem_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_MRG  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    // op[1:0] carries the access size for both signed and unsigned loads
    function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] a);
        case (op[1:0])
            2'b01:   return (a[0] == 1'b0);
            2'b10:   return (a == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic is_legal_op(input logic we, input logic [2:0] op);
        if (we)
            return (op == MOP_B) || (op == MOP_H) || (op == MOP_W);
        else
            return (op == MOP_B) || (op == MOP_H) || (op == MOP_W) ||
                   (op == MOP_BU) || (op == MOP_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - little-endian byte/half lane extract+extend for loads and lane merge for stores
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = old_word[{lane, 3'b000} +: 8];
        h = old_word[{lane[1], 4'b0000} +: 16];
        case (op)
            MOP_B:   load_data = {{24{b[7]}}, b};
            MOP_BU:  load_data = {24'd0, b};
            MOP_H:   load_data = {{16{h[15]}}, h};
            MOP_HU:  load_data = {16'd0, h};
            MOP_W:   load_data = old_word;
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        merged_word = old_word;
        case (op)
            MOP_B:   merged_word[{lane, 3'b000} +: 8]    = new_data[7:0];
            MOP_H:   merged_word[{lane[1], 4'b0000} +: 16] = new_data[15:0];
            MOP_W:   merged_word = new_data;
            default: merged_word = old_word;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - load/store unit doing aligned word access and read-modify-write sub-word stores
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    logic [2:0]  state;
    logic        we_q;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic        req_ok;
    logic        req_full_word_store;
    logic        unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W];
    assign req_ready   = (state == ST_IDLE);

    assign req_ok              = is_legal_op(req_we, req_op) && is_aligned(req_op, req_addr[1:0]);
    assign req_full_word_store = req_we && (req_op == MOP_W);

    // old_word is ram_rdata directly: it is valid exactly in MRG, the only state that consumes the unit
    dmem_lane_unit u_lane (
        .op          (op_q),
        .lane        (lane_q),
        .old_word    (ram_rdata),
        .new_data    (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            op_q      <= 3'd0;
            lane_q    <= 2'd0;
            wdata_q   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        op_q    <= req_op;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (!req_ok) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                            state     <= ST_RESP;
                        end else begin
                            ram_en    <= 1'b1;
                            ram_we    <= req_full_word_store;
                            ram_addr  <= req_addr[ADDR_W-1:2];
                            ram_wdata <= req_wdata;
                            state     <= req_full_word_store ? ST_WR : ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    state  <= ST_MRG;
                end
                ST_MRG: begin
                    if (we_q) begin
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_wdata <= merged_word;
                        state     <= ST_WR;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_data;
                        state     <= ST_RESP;
                    end
                end
                ST_WR: begin
                    ram_en    <= 1'b0;
                    ram_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 32'd0;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'd0;
                    state     <= ST_IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    ram_en    <= 1'b0;
                    ram_we    <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - vector table plus scoreboard bench for dmem_access_ctrl with a behavioural RAM
module tb_dmem_access_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_en;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'd0;

    dmem_access_ctrl #(.ADDR_W(17)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:32767];
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at_cyc;
    } exp_t;
    exp_t sb_q[$];

    int en_cnt = 0;
    int we_cnt = 0;

    always @(negedge clock) begin
        if (ram_en) en_cnt++;
        if (ram_we) we_cnt++;
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                check("rsp_cycle", cyc, e.at_cyc);
            end
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          en_pulses;
        int          we_pulses;
        int          mem_idx;
        logic [31:0] mem_val;
    } vec_t;

    task automatic issue(input vec_t v);
        exp_t e;
        int en0, we0, waited;
        @(negedge clock);
        check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
        en0 = en_cnt;
        we0 = we_cnt;
        req_valid = 1'b1;
        req_we    = v.we;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        e.rdata  = v.exp_rdata;
        e.err    = v.exp_err;
        e.at_cyc = cyc + v.lat;
        sb_q.push_back(e);
        @(negedge clock);
        req_valid = 1'b0;
        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (sb_q.size() != 0) begin
            check("rsp_timeout", 32'd1, 32'd0);
            sb_q.delete();
        end
        @(negedge clock);
        check("ram_en_cycles", en_cnt - en0, v.en_pulses);
        check("ram_we_cycles", we_cnt - we0, v.we_pulses);
        if (v.mem_idx >= 0) check("ram_word", mem[v.mem_idx], v.mem_val);
    endtask

    vec_t vecs[$];

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 32'd0;
        mem[4] = 32'h8899AABB;

        //       we   op      addr         wdata         rdata         err   lat en we  idx val
        vecs.push_back('{1'b0, 3'b010, 32'h10,      32'h0,        32'h8899AABB, 1'b0, 3, 1, 0, -1, 32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h13,      32'h0,        32'hFFFFFF88, 1'b0, 3, 1, 0, -1, 32'h0});
        vecs.push_back('{1'b0, 3'b100, 32'h13,      32'h0,        32'h00000088, 1'b0, 3, 1, 0, -1, 32'h0});
        vecs.push_back('{1'b0, 3'b001, 32'h12,      32'h0,        32'hFFFF8899, 1'b0, 3, 1, 0, -1, 32'h0});
        vecs.push_back('{1'b0, 3'b101, 32'h10,      32'h0,        32'h0000AABB, 1'b0, 3, 1, 0, -1, 32'h0});
        vecs.push_back('{1'b1, 3'b000, 32'h11,      32'h123456CC, 32'h0,        1'b0, 4, 2, 1,  4, 32'h8899CCBB});
        vecs.push_back('{1'b1, 3'b001, 32'h12,      32'h0000BEEF, 32'h0,        1'b0, 4, 2, 1,  4, 32'hBEEFCCBB});
        vecs.push_back('{1'b1, 3'b010, 32'h14,      32'hCAFEF00D, 32'h0,        1'b0, 2, 1, 1,  5, 32'hCAFEF00D});
        vecs.push_back('{1'b0, 3'b010, 32'h11,      32'h0,        32'h0,        1'b1, 1, 0, 0,  4, 32'hBEEFCCBB});
        vecs.push_back('{1'b1, 3'b001, 32'h13,      32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0,  4, 32'hBEEFCCBB});
        vecs.push_back('{1'b0, 3'b011, 32'h10,      32'h0,        32'h0,        1'b1, 1, 0, 0,  4, 32'hBEEFCCBB});
        vecs.push_back('{1'b1, 3'b100, 32'h10,      32'h11111111, 32'h0,        1'b1, 1, 0, 0,  4, 32'hBEEFCCBB});
        vecs.push_back('{1'b1, 3'b010, 32'h12,      32'h22222222, 32'h0,        1'b1, 1, 0, 0,  4, 32'hBEEFCCBB});
        vecs.push_back('{1'b0, 3'b000, 32'h12,      32'h0,        32'hFFFFFFEF, 1'b0, 3, 1, 0, -1, 32'h0});
        vecs.push_back('{1'b0, 3'b101, 32'h12,      32'h0,        32'h0000BEEF, 1'b0, 3, 1, 0, -1, 32'h0});
        vecs.push_back('{1'b0, 3'b100, 32'h10,      32'h0,        32'h000000BB, 1'b0, 3, 1, 0, -1, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h00020014, 32'h0,       32'hCAFEF00D, 1'b0, 3, 1, 0, -1, 32'h0});

        repeat (2) @(negedge clock);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("reset_ram_en",    {31'd0, ram_en},    32'd0);
        check("reset_ram_we",    {31'd0, ram_we},    32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_ram_addr",  {17'd0, ram_addr}, 32'd0);
        check("reset_ram_wdata", ram_wdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) issue(vecs[i]);

        // sb aborted by reset while in MRG: RAM word must survive untouched
        mem[4] = 32'h8899AABB;
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_op    = 3'b000;
        req_addr  = 32'h11;
        req_wdata = 32'h000000CC;
        @(negedge clock);
        req_valid = 1'b0;
        check("abort_rd_ram_en", {31'd0, ram_en}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_ram_we",    {31'd0, ram_we},    32'd0);
        check("abort_ram_en",    {31'd0, ram_en},    32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort_req_ready_after", {31'd0, req_ready}, 32'd1);
        check("abort_ram_word", mem[4], 32'h8899AABB);
        issue('{1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 3, 1, 0, 4, 32'h8899AABB});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
